sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO. Supports any DEPTH >= 2, including non-power-of-two.
//  Two read modes: standard (registered read) and first-word-fall-through (FWFT).
//  Programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
//  General buffering stage between streaming blocks; all sizing uses common::clog2/bits/max.
// PARAMETERS
//  W       8   data width, bits (>= 1)
//  DEPTH   16  number of entries (>= 2), any integer
//  FWFT    0   0: standard read, rdata valid 1 cycle after rd; 1: head word shown while !empty
//  AF_LVL  14  afull asserted when count >= AF_LVL (1..DEPTH)
//  AE_LVL  2   aempty asserted when count <= AE_LVL (0..DEPTH-1)
// PORTS
//  clk     in   1              clock, all logic on rising edge
//  rst     in   1              synchronous reset, active high
//  wr      in   1              write request
//  wdata   in   W              write data
//  rd      in   1              read request (pop)
//  rdata   out  W              read data
//  full    out  1              count == DEPTH
//  empty   out  1              count == 0
//  afull   out  1              count >= AF_LVL
//  aempty  out  1              count <= AE_LVL
//  count   out  bits(DEPTH)    current occupancy, 0..DEPTH
//  ovf     out  1              sticky: write attempted while full
//  udf     out  1              sticky: read attempted while empty
// BEHAVIOUR
//  - Reset is synchronous and active high: rst=1 at a clk edge clears wptr, rptr and count to 0.
//    Resulting outputs: empty=1, aempty=1, full=0, afull=(AF_LVL==0 ? 1 : 0) -> 0 for legal values,
//    ovf=0, udf=0, rdata=0. Memory contents are not cleared. rst overrides wr/rd in the same cycle.
//  - Accept rules: wr_ok = wr & ~full; rd_ok = rd & ~empty. Both are evaluated on pre-edge state.
//  - wr & full: write is dropped and ovf is set. rd & empty: read is dropped and udf is set.
//    ovf/udf clear only on rst.
//  - Full with wr & rd: the read is accepted, the write is dropped (full is pre-edge), count -> DEPTH-1.
//  - Empty with wr & rd: the write is accepted, the read is dropped (udf set), count -> 1.
//  - count update: count_next = count + wr_ok - rd_ok. Widths are bits(DEPTH); count never exceeds DEPTH.
//  - All flags are combinational decodes of the registered count, so they update 1 cycle after the
//    accepted operation.
//  - Pointers: width clog2(DEPTH), max(1,...). Increment modulo DEPTH: value DEPTH-1 wraps to 0.
//    This is an explicit compare, not natural overflow, and must be correct for DEPTH=5, 6, 16, ...
//  - Standard mode (FWFT=0): on rd_ok, rdata <= mem[rptr] at the edge, valid from the next cycle.
//    rdata holds its value when no read is accepted.
//  - FWFT mode (FWFT=1): rdata = mem[rptr] (asynchronous read). Valid whenever empty=0.
//    rd_ok advances to the next word. First write into an empty FIFO is visible 1 cycle later.
//  - Write into mem[wptr] on wr_ok. A read and a write to the same address in one cycle cannot
//    occur: equal pointers imply full or empty.
// STRUCTURE
//  - Package common: clog2, bits, max (existing). Add typedef-free helper
//    function automatic int ptr_w(int d) = max(1, clog2(d)).
//  - Sub-module fifo_ptr #(DEPTH): modulo-DEPTH counter. Ports clk, rst, inc, ptr. Instantiate twice.
//  - Top: memory array logic [W-1:0] mem[DEPTH], count register, flag decode, rdata path via
//    generate on FWFT.
//  - Elaboration checks ($error): DEPTH < 2, AF_LVL outside 1..DEPTH, AE_LVL outside 0..DEPTH-1.
// TESTING
//  1. DEPTH=5, W=8, FWFT=0: write 0x01..0x05. full=1 and count=5 after the 5th edge. A 6th write sets
//     ovf=1. Read 5 -> rdata 0x01..0x05, each 1 cycle after rd. Then empty=1.
//  2. DEPTH=5: write/read interleaved for 13 words (pointers wrap twice). Data order is preserved;
//     count never exceeds 5.
//  3. Full, then wr & rd together for 1 cycle: count 5 -> 4, the written word is absent from the
//     output stream, ovf=1. Empty, then wr & rd: count 0 -> 1, udf=1.
//  4. FWFT=1, DEPTH=16: write 0xA5 into empty. Next cycle empty=0 and rdata=0xA5 with no rd. rd pops
//     it; empty=1 next cycle.
//  5. AF_LVL=14, AE_LVL=2: fill 0..16 one word per cycle. aempty=1 for count 0..2, afull=1 for
//     count 14..16; both flags track exactly on drain.
//  6. Assert rst while count=7 with wr=rd=1: next cycle count=0, empty=1, ovf=udf=0, and the write is
//     not stored.

Source files
------------

// File: rtl/common.sv
// ---------------------------------------------------------------------------
// common
//   Shared sizing helpers used across the codebase.
//     clog2(n) : ceil(log2(n)), clog2(1) = 0
//     bits(n)  : bits needed to hold the value n itself (at least 1)
//     max(a,b) : larger of two integers
//     ptr_w(d) : width of an index into a d-entry array (at least 1)
// ---------------------------------------------------------------------------
package common;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return r;
  endfunction

  // Holding the value n needs clog2(n+1) bits, e.g. 16 -> 5, 5 -> 3.
  function automatic int bits(input int n);
    return max(1, clog2(n + 1));
  endfunction

  function automatic int ptr_w(input int d);
    return max(1, clog2(d));
  endfunction

endpackage : common

// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
//   Default parameter values for sync_fifo and the legality tests applied
//   to its threshold parameters at elaboration.
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_W      = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_FWFT   = 0;
  localparam int DEF_AF_LVL = 14;
  localparam int DEF_AE_LVL = 2;

  // afull threshold must be reachable and non-trivial: 1..depth.
  function automatic bit af_lvl_ok(input int lvl, input int depth);
    return (lvl >= 1) && (lvl <= depth);
  endfunction

  // aempty threshold must leave full distinguishable: 0..depth-1.
  function automatic bit ae_lvl_ok(input int lvl, input int depth);
    return (lvl >= 0) && (lvl <= depth - 1);
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if
//   Handshake / data / status bundle of sync_fifo.
//   master : the block driving wr/wdata/rd and observing status
//   slave  : the FIFO itself
//   Signals: wr, wdata[W], rd, rdata[W], full, empty, afull, aempty,
//            count[bits(DEPTH)], ovf, udf
// ---------------------------------------------------------------------------
interface sync_fifo_if
  import common::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
);

  logic                   wr;
  logic [W-1:0]           wdata;
  logic                   rd;
  logic [W-1:0]           rdata;
  logic                   full;
  logic                   empty;
  logic                   afull;
  logic                   aempty;
  logic [bits(DEPTH)-1:0] count;
  logic                   ovf;
  logic                   udf;

  modport master (
    output wr, wdata, rd,
    input  rdata, full, empty, afull, aempty, count, ovf, udf
  );

  modport slave (
    input  wr, wdata, rd,
    output rdata, full, empty, afull, aempty, count, ovf, udf
  );

endinterface : sync_fifo_if

// File: rtl/fifo_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ptr
//   Modulo-DEPTH index counter for FIFO read/write pointers.
//   clk : clock
//   rst : synchronous active-high reset, ptr -> 0
//   inc : advance by one this cycle
//   ptr : current index, 0..DEPTH-1
//   The wrap is an explicit compare against DEPTH-1 so that
//   non-power-of-two depths never index past the array.
// ---------------------------------------------------------------------------
module fifo_ptr
  import common::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  output logic [ptr_w(DEPTH)-1:0] ptr
);

  localparam int            PW   = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    ptr_next = ptr_reg;
    if (inc) begin
      ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule : fifo_ptr

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO of DEPTH (>= 2, any integer) words of W bits.
//   FWFT=0 : rdata registered, valid the cycle after an accepted rd, holds.
//   FWFT=1 : rdata shows the head word whenever empty=0; rd pops it.
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous reset, active high; clears pointers, count,
//           sticky flags and registered rdata (memory is kept)
//     bus : sync_fifo_if.slave -- wr/wdata/rd in; rdata, full, empty,
//           afull (count >= AF_LVL), aempty (count <= AE_LVL), count,
//           ovf (sticky, wr while full), udf (sticky, rd while empty)
//   All flags decode the registered count, so they follow an accepted
//   operation by one cycle.
// ---------------------------------------------------------------------------
module sync_fifo
  import common::*;
  import sync_fifo_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FWFT   = DEF_FWFT,
  parameter int AF_LVL = DEF_AF_LVL,
  parameter int AE_LVL = DEF_AE_LVL
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = bits(DEPTH);

  // Elaboration-time parameter checks.
  generate
    if (W < 1) begin : g_chk_w
      $error("sync_fifo: W must be >= 1 (got %0d)", W);
    end
    if (DEPTH < 2) begin : g_chk_depth
      $error("sync_fifo: DEPTH must be >= 2 (got %0d)", DEPTH);
    end
    if (!af_lvl_ok(AF_LVL, DEPTH)) begin : g_chk_af
      $error("sync_fifo: AF_LVL must be in 1..DEPTH (got %0d)", AF_LVL);
    end
    if (!ae_lvl_ok(AE_LVL, DEPTH)) begin : g_chk_ae
      $error("sync_fifo: AE_LVL must be in 0..DEPTH-1 (got %0d)", AE_LVL);
    end
  endgenerate

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          ovf_reg;
  logic          udf_reg;
  logic          full;
  logic          empty;
  logic          wr_ok;
  logic          rd_ok;

  // Occupancy decode; everything below keys off the pre-edge count.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // A write into a full FIFO is dropped even if a read frees a slot in the
  // same cycle; symmetrically a read of an empty FIFO is dropped even if a
  // write lands in the same cycle.
  assign wr_ok = bus.wr & ~full;
  assign rd_ok = bus.rd & ~empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (bus.wr & full) begin
        ovf_reg <= 1'b1;
      end
      if (bus.rd & empty) begin
        udf_reg <= 1'b1;
      end
    end
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_ok),
    .ptr (wptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_ok),
    .ptr (rptr)
  );

  // Storage has no reset. The write is also suppressed under rst so a
  // request coinciding with reset leaves no trace in the array.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wptr] <= bus.wdata;
    end
  end

  // Read path. Equal pointers only occur when full or empty, so a
  // same-address read and write in one cycle cannot happen.
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdata = mem[rptr];
    end else begin : g_std
      logic [W-1:0] rdata_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_reg <= '0;
        end else if (rd_ok) begin
          rdata_reg <= mem[rptr];
        end
      end

      assign bus.rdata = rdata_reg;
    end
  endgenerate

  assign bus.full   = full;
  assign bus.empty  = empty;
  assign bus.afull  = (count_reg >= CW'(AF_LVL));
  assign bus.aempty = (count_reg <= CW'(AE_LVL));
  assign bus.count  = count_reg;
  assign bus.ovf    = ovf_reg;
  assign bus.udf    = udf_reg;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Two instances: A = standard read, DEPTH=5; B = FWFT, DEPTH=16.
//   Reference model: a queue per FIFO plus sticky error bits; outputs are
//   compared one cycle after each clock edge.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

  localparam int DA   = 5;
  localparam int DB   = 16;
  localparam int AF_A = 4;
  localparam int AE_A = 1;
  localparam int AF_B = 14;
  localparam int AE_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_if #(.W(8), .DEPTH(DA)) bus_a ();
  sync_fifo_if #(.W(8), .DEPTH(DB)) bus_b ();

  sync_fifo #(.W(8), .DEPTH(DA), .FWFT(0), .AF_LVL(AF_A), .AE_LVL(AE_A)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_fifo #(.W(8), .DEPTH(DB), .FWFT(1), .AF_LVL(AF_B), .AE_LVL(AE_B)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         ovf_a, udf_a, ovf_b, udf_b;
  logic [7:0] rdata_a_exp;

  int checks = 0;
  int errors = 0;

  task automatic drive(input bit aw, input logic [7:0] ad, input bit ar,
                       input bit bw, input logic [7:0] bd, input bit br);
    bus_a.wr = aw; bus_a.wdata = ad; bus_a.rd = ar;
    bus_b.wr = bw; bus_b.wdata = bd; bus_b.rd = br;
  endtask

  // One clock edge; the model applies the same accept rules to the
  // pre-edge occupancy, then outputs settle for sampling.
  task automatic tick();
    bit a_wok, a_rok, b_wok, b_rok;
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
      ovf_a = 0; udf_a = 0; ovf_b = 0; udf_b = 0;
      rdata_a_exp = 8'h00;
    end else begin
      a_wok = bus_a.wr && (qa.size() < DA);
      a_rok = bus_a.rd && (qa.size() > 0);
      b_wok = bus_b.wr && (qb.size() < DB);
      b_rok = bus_b.rd && (qb.size() > 0);
      if (bus_a.wr && !a_wok) ovf_a = 1;
      if (bus_a.rd && !a_rok) udf_a = 1;
      if (bus_b.wr && !b_wok) ovf_b = 1;
      if (bus_b.rd && !b_rok) udf_b = 1;
      if (a_rok) rdata_a_exp = qa.pop_front();
      if (a_wok) qa.push_back(bus_a.wdata);
      if (b_rok) void'(qb.pop_front());
      if (b_wok) qb.push_back(bus_b.wdata);
    end
    #1;
  endtask

  function automatic logic [5:0] exp_flags_a();
    return {qa.size() == DA, qa.size() == 0, qa.size() >= AF_A,
            qa.size() <= AE_A, ovf_a, udf_a};
  endfunction

  function automatic logic [5:0] exp_flags_b();
    return {qb.size() == DB, qb.size() == 0, qb.size() >= AF_B,
            qb.size() <= AE_B, ovf_b, udf_b};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_a.count !== 3'd0) begin
      errors++; $display("FAIL reset_count_a: got %0d expected 0", bus_a.count);
    end
    checks++;
    if ({bus_a.full, bus_a.empty, bus_a.afull, bus_a.aempty, bus_a.ovf, bus_a.udf} !== 6'b010100) begin
      errors++; $display("FAIL reset_flags_a: got %b expected 010100",
        {bus_a.full, bus_a.empty, bus_a.afull, bus_a.aempty, bus_a.ovf, bus_a.udf});
    end
    checks++;
    if (bus_a.rdata !== 8'h00) begin
      errors++; $display("FAIL reset_rdata_a: got %h expected 00", bus_a.rdata);
    end
    checks++;
    if ({bus_b.count, bus_b.full, bus_b.empty, bus_b.afull, bus_b.aempty, bus_b.ovf, bus_b.udf} !== {5'd0, 6'b010100}) begin
      errors++; $display("FAIL reset_b: got count %0d flags %b expected 0 010100", bus_b.count,
        {bus_b.full, bus_b.empty, bus_b.afull, bus_b.aempty, bus_b.ovf, bus_b.udf});
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 8'(i), 0, 0, 8'h00, 0);
      tick();
      checks++;
      if (bus_a.count !== 3'(i)) begin
        errors++; $display("FAIL fill_count: got %0d expected %0d", bus_a.count, i);
      end
    end
    checks++;
    if (bus_a.full !== 1'b1) begin
      errors++; $display("FAIL fill_full: got %b expected 1", bus_a.full);
    end
    drive(1, 8'h06, 0, 0, 8'h00, 0);
    tick();
    checks++;
    if ({bus_a.ovf, bus_a.count} !== {1'b1, 3'd5}) begin
      errors++; $display("FAIL fill_ovf: got ovf %b count %0d expected 1 5", bus_a.ovf, bus_a.count);
    end
    for (int i = 1; i <= 5; i++) begin
      drive(0, 8'h00, 1, 0, 8'h00, 0);
      tick();
      checks++;
      if (bus_a.rdata !== 8'(i)) begin
        errors++; $display("FAIL drain_rdata: got %h expected %h", bus_a.rdata, 8'(i));
      end
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    tick();
    checks++;
    if ({bus_a.empty, bus_a.rdata} !== {1'b1, 8'h05}) begin
      errors++; $display("FAIL drain_empty_hold: got empty %b rdata %h expected 1 05", bus_a.empty, bus_a.rdata);
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_wrap();
    int wrote, got, cyc;
    bit w, r, racc;
    do_reset();
    wrote = 0; got = 0; cyc = 0;
    while (got < 13 && cyc < 400) begin
      w = (wrote < 13) && ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 1) != 0);
      racc = r && (qa.size() > 0);
      if (w && qa.size() < DA) wrote++;
      drive(w, 8'(8'h30 + wrote - 1), r, 0, 8'h00, 0);
      tick();
      cyc++;
      if (racc) begin
        checks++;
        if (bus_a.rdata !== 8'(8'h30 + got)) begin
          errors++; $display("FAIL wrap_order: got %h expected %h", bus_a.rdata, 8'(8'h30 + got));
        end
        got++;
      end
      checks++;
      if (bus_a.count !== 3'(qa.size()) || bus_a.count > 3'd5) begin
        errors++; $display("FAIL wrap_count: got %0d expected %0d", bus_a.count, qa.size());
      end
    end
    checks++;
    if (got != 13) begin
      errors++; $display("FAIL wrap_timeout: got %0d words expected 13", got);
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    $display("test_wrap done: %0d cycles", cyc);
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h41 + i), 0, 0, 8'h00, 0);
      tick();
    end
    drive(1, 8'hEE, 1, 0, 8'h00, 0);
    tick();
    checks++;
    if ({bus_a.count, bus_a.ovf, bus_a.rdata} !== {3'd4, 1'b1, 8'h41}) begin
      errors++; $display("FAIL full_wr_rd: got count %0d ovf %b rdata %h expected 4 1 41",
        bus_a.count, bus_a.ovf, bus_a.rdata);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'h00, 1, 0, 8'h00, 0);
      tick();
      checks++;
      if (bus_a.rdata !== 8'(8'h42 + i)) begin
        errors++; $display("FAIL full_wr_rd_stream: got %h expected %h", bus_a.rdata, 8'(8'h42 + i));
      end
    end
    drive(1, 8'h99, 1, 0, 8'h00, 0);
    tick();
    checks++;
    if ({bus_a.count, bus_a.udf} !== {3'd1, 1'b1}) begin
      errors++; $display("FAIL empty_wr_rd: got count %0d udf %b expected 1 1", bus_a.count, bus_a.udf);
    end
    drive(0, 8'h00, 1, 0, 8'h00, 0);
    tick();
    checks++;
    if ({bus_a.rdata, bus_a.empty} !== {8'h99, 1'b1}) begin
      errors++; $display("FAIL empty_wr_rd_data: got rdata %h empty %b expected 99 1", bus_a.rdata, bus_a.empty);
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    $display("test_simultaneous done");
  endtask

  task automatic test_fwft();
    do_reset();
    drive(0, 8'h00, 0, 1, 8'hA5, 0);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    checks++;
    if ({bus_b.empty, bus_b.rdata} !== {1'b0, 8'hA5}) begin
      errors++; $display("FAIL fwft_show: got empty %b rdata %h expected 0 a5", bus_b.empty, bus_b.rdata);
    end
    tick();
    checks++;
    if (bus_b.rdata !== 8'hA5) begin
      errors++; $display("FAIL fwft_hold: got %h expected a5", bus_b.rdata);
    end
    drive(0, 8'h00, 0, 0, 8'h00, 1);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    checks++;
    if ({bus_b.empty, bus_b.count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL fwft_pop: got empty %b count %0d expected 1 0", bus_b.empty, bus_b.count);
    end
    $display("test_fwft done");
  endtask

  task automatic test_levels();
    do_reset();
    for (int i = 0; i <= DB; i++) begin
      checks++;
      if ({bus_b.count, bus_b.afull, bus_b.aempty} !== {5'(i), i >= 14, i <= 2}) begin
        errors++; $display("FAIL level_fill: got count %0d afull %b aempty %b expected %0d %b %b",
          bus_b.count, bus_b.afull, bus_b.aempty, i, i >= 14, i <= 2);
      end
      drive(0, 8'h00, 0, 1, 8'($urandom), 0);
      tick();
    end
    // last iteration above wrote into a full FIFO
    checks++;
    if ({bus_b.ovf, bus_b.full} !== 2'b11) begin
      errors++; $display("FAIL level_ovf: got ovf %b full %b expected 1 1", bus_b.ovf, bus_b.full);
    end
    for (int i = DB; i >= 0; i--) begin
      checks++;
      if ({bus_b.count, bus_b.afull, bus_b.aempty} !== {5'(i), i >= 14, i <= 2}) begin
        errors++; $display("FAIL level_drain: got count %0d afull %b aempty %b expected %0d %b %b",
          bus_b.count, bus_b.afull, bus_b.aempty, i, i >= 14, i <= 2);
      end
      if (i > 0) begin
        checks++;
        if (bus_b.rdata !== qb[0]) begin
          errors++; $display("FAIL level_head: got %h expected %h", bus_b.rdata, qb[0]);
        end
      end
      drive(0, 8'h00, 0, 0, 8'h00, 1);
      tick();
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    checks++;
    if ({bus_b.udf, bus_b.ovf} !== 2'b11) begin
      errors++; $display("FAIL level_udf: got udf %b ovf %b expected 1 1", bus_b.udf, bus_b.ovf);
    end
    $display("test_levels done");
  endtask

  task automatic test_reset_busy();
    for (int i = 0; i < 7; i++) begin
      drive(0, 8'h00, 0, 1, 8'(8'h60 + i), 0);
      tick();
    end
    drive(0, 8'h00, 0, 1, 8'h77, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    checks++;
    if ({bus_b.count, bus_b.empty, bus_b.ovf, bus_b.udf} !== {5'd0, 3'b100}) begin
      errors++; $display("FAIL reset_busy: got count %0d empty %b ovf %b udf %b expected 0 1 0 0",
        bus_b.count, bus_b.empty, bus_b.ovf, bus_b.udf);
    end
    drive(0, 8'h00, 0, 1, 8'h11, 0);
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    checks++;
    if ({bus_b.count, bus_b.rdata} !== {5'd1, 8'h11}) begin
      errors++; $display("FAIL reset_busy_after: got count %0d rdata %h expected 1 11", bus_b.count, bus_b.rdata);
    end
    $display("test_reset_busy done");
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 50);
      tick();
      checks++;
      if ({bus_a.count, bus_a.full, bus_a.empty, bus_a.afull, bus_a.aempty, bus_a.ovf, bus_a.udf, bus_a.rdata}
          !== {3'(qa.size()), exp_flags_a(), rdata_a_exp}) begin
        errors++; $display("FAIL random_a: got count %0d flags %b rdata %h expected %0d %b %h",
          bus_a.count, {bus_a.full, bus_a.empty, bus_a.afull, bus_a.aempty, bus_a.ovf, bus_a.udf},
          bus_a.rdata, qa.size(), exp_flags_a(), rdata_a_exp);
      end
      checks++;
      if ({bus_b.count, bus_b.full, bus_b.empty, bus_b.afull, bus_b.aempty, bus_b.ovf, bus_b.udf}
          !== {5'(qb.size()), exp_flags_b()}) begin
        errors++; $display("FAIL random_b: got count %0d flags %b expected %0d %b", bus_b.count,
          {bus_b.full, bus_b.empty, bus_b.afull, bus_b.aempty, bus_b.ovf, bus_b.udf}, qb.size(), exp_flags_b());
      end
      if (qb.size() > 0) begin
        checks++;
        if (bus_b.rdata !== qb[0]) begin
          errors++; $display("FAIL random_b_head: got %h expected %h", bus_b.rdata, qb[0]);
        end
      end
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    $display("test_random done");
  endtask

  initial begin
    drive(0, 8'h00, 0, 0, 8'h00, 0);
    rdata_a_exp = 8'h00;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_levels();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo
